// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, saturation limits and capture state encoding for the FIR output path
package fir_pkg;
  localparam int FIR_OUT_W = 14;
  localparam int DOUT_W    = 8;
  localparam int SAT_MAX   = 127;
  localparam int SAT_MIN   = -128;
  typedef enum logic [1:0] {IDLE, FILL, RUN} cap_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-bit pointers; Dout reads 0 while empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Full,
  output logic             Empty,
  output logic [AW:0]      Count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign Empty   = wr_ptr == rd_ptr;
  assign Full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign Count   = wr_ptr - rd_ptr;
  assign do_pop  = Pop && !Empty;
  assign do_push = Push && (!Full || do_pop);
  assign Dout    = Empty ? '0 : mem[rd_ptr[AW-1:0]];
  // pointers advance on accepted push/pop; the extra MSB distinguishes full from empty
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  // storage needs no reset: an entry is only visible once written
  always_ff @(posedge Clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= Din;
endmodule

// File: rtl/fir_out_capture.sv
// fir_out_capture: drops FIR pipeline-fill samples, rescales to 8-bit and queues them for a valid/ready sink
module fir_out_capture
  import fir_pkg::*;
#(
  parameter int TAPS  = 13,
  parameter int SHIFT = 6,
  parameter int DEPTH = 8
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [FIR_OUT_W-1:0]   Fir_out,
  input  logic                   En,
  input  logic                   Start,
  input  logic                   Stop,
  output logic [DOUT_W-1:0]      Dout,
  output logic                   Dout_valid,
  input  logic                   Dout_ready,
  output logic                   Filling,
  output logic                   Ovf,
  output logic [$clog2(DEPTH):0] Count
);
  localparam int CW = $clog2(TAPS);
  localparam logic signed [FIR_OUT_W:0] HALF = (FIR_OUT_W+1)'(1 << (SHIFT-1));
  cap_state_t state, state_nxt;
  logic [CW-1:0] fill_cnt, fill_nxt;
  logic signed [FIR_OUT_W:0] biased, shifted;
  logic [DOUT_W-1:0] scaled;
  logic push, pop, full, empty;
  // round half up, arithmetic shift, then clamp to the signed 8-bit range
  always_comb begin
    biased  = $signed({Fir_out[FIR_OUT_W-1], Fir_out}) + HALF;
    shifted = biased >>> SHIFT;
    scaled  = shifted > SAT_MAX ? DOUT_W'(SAT_MAX) :
              shifted < SAT_MIN ? DOUT_W'(SAT_MIN) : shifted[DOUT_W-1:0];
  end
  // Start overrides everything, Stop exits capture, FILL counts off TAPS-1 discarded samples
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    if (Start) begin
      state_nxt = FILL;
      fill_nxt  = '0;
    end else if (Stop && state != IDLE) begin
      state_nxt = IDLE;
    end else if (state == FILL && En) begin
      fill_nxt  = fill_cnt + 1'b1;
      state_nxt = fill_cnt == CW'(TAPS-2) ? RUN : FILL;
    end
  end
  assign push       = state == RUN && En && !Start && !Stop;
  assign pop        = Dout_valid && Dout_ready;
  assign Dout_valid = !empty;
  assign Filling    = state == FILL;
  // state, fill counter and sticky overflow flag (cleared by a new Start)
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state    <= IDLE;
      fill_cnt <= '0;
      Ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= fill_nxt;
      Ovf      <= Start ? 1'b0 : Ovf || (push && full && !pop);
    end
  sync_fifo #(.WIDTH(DOUT_W), .DEPTH(DEPTH)) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Push  (push),
    .Pop   (pop),
    .Din   (scaled),
    .Dout  (Dout),
    .Full  (full),
    .Empty (empty),
    .Count (Count)
  );
endmodule

// File: tb/tb_fir_out_capture.sv
// tb_fir_out_capture: directed stimulus with a scoreboard queue checked by an output monitor
module tb_fir_out_capture;
  logic Clk = 1'b0, Rst_n = 1'b0;
  logic [13:0] Fir_out = '0;
  logic En = 1'b0, Start = 1'b0, Stop = 1'b0, Dout_ready = 1'b0;
  logic [7:0] Dout;
  logic Dout_valid, Filling, Ovf;
  logic [3:0] Count;
  int n_vec = 0, n_err = 0, fill_cycles;
  logic [7:0] exp_q [$];

  always #5 Clk = ~Clk;

  fir_out_capture dut (
    .Clk(Clk), .Rst_n(Rst_n), .Fir_out(Fir_out), .En(En), .Start(Start), .Stop(Stop),
    .Dout(Dout), .Dout_valid(Dout_valid), .Dout_ready(Dout_ready),
    .Filling(Filling), .Ovf(Ovf), .Count(Count)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic smp(input int v, input bit p, input logic [7:0] e);
    Fir_out = 14'(v);
    En = 1'b1;
    if (p) exp_q.push_back(e);
    tick();
    En = 1'b0;
  endtask

  task automatic discard12;
    for (int i = 0; i < 12; i++) smp(64 * 50, 1'b0, 8'h00);
  endtask

  // every accepted output must match the oldest expected sample
  always @(negedge Clk)
    if (Rst_n && Dout_valid && Dout_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dout_unexpected: got %0h required no output", Dout);
      end else begin
        chk("dout", int'(Dout), int'(exp_q.pop_front()));
      end
    end

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_dout", Dout, 0);
    chk("rst_valid", Dout_valid, 0);
    chk("rst_filling", Filling, 0);
    chk("rst_ovf", Ovf, 0);
    chk("rst_count", Count, 0);
    Rst_n = 1'b1;
    tick();
    // fill discard and rounding
    Dout_ready = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("filling_after_start", Filling, 1);
    fill_cycles = 0;
    for (int i = 0; i <= 20; i++) begin
      fill_cycles += int'(Filling);
      smp(i, i >= 12, 8'h00);
    end
    chk("fill_cycles", fill_cycles, 12);
    smp(100, 1'b1, 8'h02);
    smp(-100, 1'b1, 8'hFE);
    // saturation and rounding edges
    smp(8191, 1'b1, 8'h7F);
    smp(-8192, 1'b1, 8'h80);
    smp(8159, 1'b1, 8'h7F);
    smp(31, 1'b1, 8'h00);
    smp(32, 1'b1, 8'h01);
    repeat (3) tick();
    chk("count_drained1", Count, 0);
    chk("valid_drained1", Dout_valid, 0);
    // backpressure and overflow
    Dout_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      smp(64 * k, k <= 8, 8'(k));
      if (k == 8) begin
        chk("count_full", Count, 8);
        chk("ovf_before_drop", Ovf, 0);
      end
      if (k == 9) begin
        chk("ovf_on_drop", Ovf, 1);
        chk("count_stays_full", Count, 8);
      end
    end
    chk("count_after_drops", Count, 8);
    Dout_ready = 1'b1;
    repeat (10) tick();
    chk("count_drained2", Count, 0);
    chk("ovf_sticky", Ovf, 1);
    // full FIFO with simultaneous push and pop
    Dout_ready = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("ovf_cleared_by_start", Ovf, 0);
    chk("filling_restart", Filling, 1);
    discard12();
    for (int k = 11; k <= 18; k++) smp(64 * k, 1'b1, 8'(k));
    chk("count_full2", Count, 8);
    Dout_ready = 1'b1;
    for (int k = 19; k <= 22; k++) begin
      smp(64 * k, 1'b1, 8'(k));
      chk("count_full_pushpop", Count, 8);
      chk("ovf_full_pushpop", Ovf, 0);
    end
    repeat (10) tick();
    chk("count_drained3", Count, 0);
    // Stop in RUN blocks pushes while the FIFO keeps draining
    Dout_ready = 1'b0;
    for (int k = 23; k <= 25; k++) smp(64 * k, 1'b1, 8'(k));
    Stop = 1'b1;
    smp(64 * 26, 1'b0, 8'h00);
    Stop = 1'b0;
    chk("filling_after_stop", Filling, 0);
    smp(64 * 27, 1'b0, 8'h00);
    chk("count_after_stop", Count, 3);
    Dout_ready = 1'b1;
    repeat (5) tick();
    chk("count_drained4", Count, 0);
    // Start and Stop together: Start wins
    Start = 1'b1;
    Stop = 1'b1;
    tick();
    Start = 1'b0;
    Stop = 1'b0;
    chk("filling_start_stop", Filling, 1);
    discard12();
    smp(64 * 30, 1'b1, 8'd30);
    // Start in RUN re-discards the fill samples
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("filling_start_in_run", Filling, 1);
    discard12();
    smp(64 * 31, 1'b1, 8'd31);
    repeat (3) tick();
    chk("count_drained5", Count, 0);
    // asynchronous reset mid-FILL with entries queued
    Dout_ready = 1'b0;
    for (int k = 1; k <= 3; k++) smp(64 * k, 1'b1, 8'(k));
    Start = 1'b1;
    tick();
    Start = 1'b0;
    smp(0, 1'b0, 8'h00);
    smp(0, 1'b0, 8'h00);
    chk("count_before_areset", Count, 3);
    chk("filling_before_areset", Filling, 1);
    #3 Rst_n = 1'b0;
    #1;
    chk("areset_dout", Dout, 0);
    chk("areset_valid", Dout_valid, 0);
    chk("areset_filling", Filling, 0);
    chk("areset_ovf", Ovf, 0);
    chk("areset_count", Count, 0);
    exp_q.delete();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    tick();
    chk("idle_after_release", Filling, 0);
    Dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) smp(64 * 5, 1'b0, 8'h00);
    tick();
    chk("idle_no_push_valid", Dout_valid, 0);
    chk("idle_no_push_count", Count, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fir_out_capture.md
# fir_out_capture

Output-side collector for the transposed-form FIR high-pass filter. It takes the filter's 14-bit signed output stream and discards the pipeline-fill samples after each start. It rescales each remaining sample with round-half-up and saturation to 8-bit signed, buffers it in a small FIFO, and presents it to downstream logic over a valid/ready handshake. It sits directly on the FIR `Out` port and runs in the same clock domain.

## Interface
- `TAPS`, 13: filter length; the fill-discard count is `TAPS-1`.
- `SHIFT`, 6: right-shift applied before saturation; must be ≥1.
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `Clk`  in  1  system clock, rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Fir_out`  in  14  signed FIR output sample.
- `En`  in  1  `Fir_out` holds a new sample this cycle.
- `Start`  in  1  one-cycle pulse that (re)arms capture.
- `Stop`  in  1  one-cycle pulse that halts capture.
- `Dout`  out  8  signed rescaled sample at the FIFO head.
- `Dout_valid`  out  1  `Dout` holds valid data.
- `Dout_ready`  in  1  downstream accepts `Dout`.
- `Filling`  out  1  high while in FILL.
- `Ovf`  out  1  sticky: a sample was dropped because the FIFO was full.
- `Count`  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **States:** IDLE, FILL, RUN. Reset enters IDLE.
- **IDLE:**
  - `Start` → FILL; the fill counter loads 0.
- **FILL:**
  - Each `En` cycle increments the fill counter and the sample is discarded.
  - When `En` arrives with the counter at `TAPS-2`, the state moves to RUN. That sample is also discarded, so exactly `TAPS-1` samples are dropped.
  - Samples are dropped only on `En` cycles.
- **RUN:**
  - Each `En` cycle pushes the rescaled sample into the FIFO.
- **Start / Stop priority:**
  - `Stop` in FILL or RUN → IDLE. A sample with `En` in the same cycle is not pushed.
  - `Start` in any state → FILL with the fill counter reset. `Start` also clears `Ovf`.
  - `Start` and `Stop` in the same cycle: `Start` wins.
  - FIFO contents are never flushed by `Start` or `Stop`. Only reset empties the FIFO.
- **Rescale:**
  - Sign-extend `Fir_out` to 15 bits and add 2^(SHIFT-1).
  - Arithmetic-shift right by `SHIFT`.
  - Saturate to [-128, 127].
  - Fully combinational, ahead of the FIFO write.
- **FIFO:**
  - Push = RUN & `En` & no `Stop`/`Start` this cycle.
  - Pop = `Dout_valid` & `Dout_ready`.
  - `Dout` = head entry, and `Dout_valid` = not empty.
  - `Dout` holds its value while `Dout_valid` is high and `Dout_ready` is low.
- **Boundaries:**
  - Push + pop with FIFO full: both occur and occupancy is unchanged.
  - Push with FIFO full and no pop: the sample is dropped, `Ovf` is set and occupancy stays `DEPTH`.
  - Push + pop with FIFO empty: no pop, because `Dout_valid` is low. The pushed sample appears next cycle.
  - Read and write pointers wrap modulo `DEPTH`. Occupancy is tracked with an extra pointer bit.
- **Reset** (asynchronous, any cycle, including mid-FILL or with the FIFO part-full):
  - State IDLE, pointers 0, fill counter 0.
  - `Dout`=0, `Dout_valid`=0, `Filling`=0, `Ovf`=0, `Count`=0.

## Timing
- A sample pushed at rising edge k is visible on `Dout`, with `Dout_valid`=1, after edge k when the FIFO was empty.
- A pop at edge k presents the next entry after edge k.
- `Count`, `Filling` and `Ovf` are registered and update on the same edge as the event that changes them.
- First captured sample after `Start` at edge s with `En` held high: the sample from cycle s+`TAPS-1` (s+12 at the defaults) is pushed at edge s+`TAPS`.
- Throughput: one sample per cycle sustained when `Dout_ready` is held high.
- The path from `Fir_out` through the add, shift and saturate logic to the FIFO write port is combinational within one cycle.

## Structure
- A shared package `fir_pkg` holds:
  - data widths: `FIR_OUT_W`=14, `DOUT_W`=8;
  - the state enum `cap_state_t` {IDLE, FILL, RUN};
  - saturation limits `SAT_MAX`=127, `SAT_MIN`=-128.
- One sub-module, `sync_fifo`: parameterised width and depth, async active-low reset, push/pop/full/empty/count.
- The FSM, fill counter and rescale logic stay in `fir_out_capture`.

## Test plan
- **Reset and fill discard.** Reset, then `Start`, `En`=1, `Fir_out` = sample index 0..20, `Dout_ready`=1. Expect:
  - samples 0..11 discarded and `Filling` high for 12 cycles;
  - the first `Dout_valid`=1 carries round(12/64)=0;
  - `Fir_out`=100 → `Dout`=2;
  - `Fir_out`=-100 → `Dout`=-2.
- **Saturation in RUN.** Expect:
  - 8191 → 127;
  - -8192 → -128;
  - 8159 → 127, since 8191>>6 = 127;
  - 31 → 0 and 32 → 1.
- **Backpressure and overflow.** `Dout_ready`=0 in RUN with `En`=1 for 10 cycles. Expect:
  - `Count` reaches 8;
  - `Ovf` rises on the 9th push;
  - the two extra samples are lost;
  - draining yields exactly the first 8 samples in order.
- **Full with simultaneous push and pop.** FIFO full, `Dout_ready`=1, `En`=1. Expect `Count` to stay 8, no `Ovf`, and the sample order preserved.
- **Mid-operation control.**
  - `Stop` during RUN → no further pushes, and the FIFO keeps draining.
  - `Start` in RUN → `Ovf` cleared and 12 samples discarded again.
  - `Start`+`Stop` in the same cycle → FILL.
- **Asynchronous reset.** `Rst_n` low mid-FILL with 3 entries queued. Expect all outputs 0 immediately, without waiting for a clock edge, and IDLE on release.
